// File: rtl/ccg_bist_pkg.sv
//------------------------------------------------------------------------------
// ccg_bist_pkg : shared types, default constants and signature step function
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ccg_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bist_state_e;

   localparam int          DEF_N_IN      = 6;
   localparam int          DEF_N_OUT     = 4;
   localparam int          DEF_N_PAT     = 63;
   localparam int          DEF_SETTLE    = 1;
   localparam int          DEF_SIG_W     = 16;
   localparam logic [5:0]  DEF_LFSR_TAPS = 6'b100001;
   localparam logic [5:0]  DEF_LFSR_SEED = 6'b000001;
   localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
   localparam logic [15:0] DEF_GOLDEN    = 16'h0000;

   // One signature step on values zero-extended to 32 bits; w is the live width.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] poly,
                                             input logic [31:0] d,
                                             input int          w);
      logic [31:0] mask;
      logic [31:0] nxt;
      logic        msb;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      msb  = |(sig & (32'd1 << (w - 1)));
      nxt  = (sig << 1) ^ (msb ? poly : 32'd0) ^ d;
      return nxt & mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ccg_misr.sv
//------------------------------------------------------------------------------
// ccg_misr : multiple-input signature register with clear and enable
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ccg_misr
   import ccg_bist_pkg::*;
#(
   parameter int               SIG_W = DEF_SIG_W,
   parameter int               D_W   = DEF_N_OUT,
   parameter logic [SIG_W-1:0] POLY  = DEF_MISR_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [D_W-1:0]   d,
   output logic [SIG_W-1:0] sig
);

   localparam logic [31:0] POLY_EXT = 32'(POLY);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;
   logic [31:0]      step;

   always_comb begin
      step  = misr_step(32'(sig_q), POLY_EXT, 32'(d), SIG_W);
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = SIG_W'(step);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/ccg_bist_harness.sv
//------------------------------------------------------------------------------
// ccg_bist_harness : LFSR stimulus, MISR response compaction and run control
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ccg_bist_harness
   import ccg_bist_pkg::*;
#(
   parameter int               N_IN      = DEF_N_IN,
   parameter int               N_OUT     = DEF_N_OUT,
   parameter int               N_PAT     = DEF_N_PAT,
   parameter int               SETTLE    = DEF_SETTLE,
   parameter logic [N_IN-1:0]  LFSR_TAPS = DEF_LFSR_TAPS,
   parameter logic [N_IN-1:0]  LFSR_SEED = DEF_LFSR_SEED,
   parameter int               SIG_W     = DEF_SIG_W,
   parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY,
   parameter logic [SIG_W-1:0] GOLDEN    = DEF_GOLDEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [N_OUT-1:0] f_i,
   output logic [N_IN-1:0]  x_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [SIG_W-1:0] sig_o,
   output logic [15:0]      pat_cnt_o
);

   localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE);
   localparam logic [15:0] PAT_LAST    = 16'(N_PAT - 1);
   localparam logic [31:0] POLY_EXT    = 32'(MISR_POLY);
   localparam logic [31:0] GOLDEN_EXT  = 32'(GOLDEN);

   bist_state_e      state_q, state_d;
   logic [N_IN-1:0]  x_q, x_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [2:0]       settle_q, settle_d;
   logic             pass_q, pass_d;
   logic             misr_clr;
   logic             misr_en;
   logic [N_IN-1:0]  lfsr_next;
   logic             capture;
   logic [SIG_W-1:0] sig;
   logic [31:0]      sig_next;

   assign lfsr_next = {x_q[N_IN-2:0], ^(x_q & LFSR_TAPS)};
   assign capture   = (settle_q == SETTLE_LAST);
   // Verdict is taken from the signature the final capture is about to write,
   // so pass_o is already valid in the DONE cycle alongside done_o.
   assign sig_next  = misr_step(32'(sig), POLY_EXT, 32'(f_i), SIG_W);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      pass_d   = pass_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               x_d      = LFSR_SEED;
               cnt_d    = '0;
               settle_d = '0;
               pass_d   = 1'b0;
               misr_clr = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (capture) begin
               misr_en  = 1'b1;
               x_d      = lfsr_next;
               cnt_d    = cnt_q + 16'd1;
               settle_d = '0;
               if (cnt_q == PAT_LAST) begin
                  pass_d  = (sig_next == GOLDEN_EXT);
                  state_d = ST_DONE;
               end
            end else begin
               settle_d = settle_q + 3'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         cnt_q    <= '0;
         settle_q <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         pass_q   <= pass_d;
      end
   end

   ccg_misr #(
      .SIG_W (SIG_W),
      .D_W   (N_OUT),
      .POLY  (MISR_POLY)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (misr_clr),
      .en  (misr_en),
      .d   (f_i),
      .sig (sig)
   );

   assign x_o       = x_q;
   assign busy_o    = (state_q == ST_RUN);
   assign done_o    = (state_q == ST_DONE);
   assign pass_o    = pass_q;
   assign sig_o     = sig;
   assign pat_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ccg_bist_harness.sv
//------------------------------------------------------------------------------
// tb_ccg_bist_harness : directed/random runs of three harness configurations
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ccg_bist_harness;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_r [3];
   logic [3:0] f_r     [3];

   logic [5:0]  x_a, x_b, x_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   logic        pass_a, pass_b, pass_c;
   logic [15:0] sig_a, sig_b, sig_c;
   logic [15:0] cnt_a, cnt_b, cnt_c;

   int n_tests = 0;
   int n_fail  = 0;
   int sel     = 0;

   logic [5:0]  m_x;
   logic        m_busy, m_done, m_pass;
   logic [15:0] m_sig, m_cnt;
   logic [5:0]  obs_x [$];

   always #5 clk = ~clk;

   ccg_bist_harness dut_a (
      .clk(clk), .rst(rst), .start_i(start_r[0]), .f_i(f_r[0]), .x_o(x_a),
      .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .sig_o(sig_a), .pat_cnt_o(cnt_a));

   ccg_bist_harness #(.N_PAT(2), .SETTLE(1)) dut_b (
      .clk(clk), .rst(rst), .start_i(start_r[1]), .f_i(f_r[1]), .x_o(x_b),
      .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .sig_o(sig_b), .pat_cnt_o(cnt_b));

   ccg_bist_harness #(.N_PAT(3), .SETTLE(0), .GOLDEN(16'h0007)) dut_c (
      .clk(clk), .rst(rst), .start_i(start_r[2]), .f_i(f_r[2]), .x_o(x_c),
      .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .sig_o(sig_c), .pat_cnt_o(cnt_c));

   always_comb begin
      m_x = x_a; m_busy = busy_a; m_done = done_a; m_pass = pass_a; m_sig = sig_a; m_cnt = cnt_a;
      case (sel)
         1: begin m_x = x_b; m_busy = busy_b; m_done = done_b; m_pass = pass_b; m_sig = sig_b; m_cnt = cnt_b; end
         2: begin m_x = x_c; m_busy = busy_c; m_done = done_c; m_pass = pass_c; m_sig = sig_c; m_cnt = cnt_c; end
         default: ;
      endcase
   end

   // Signature as GF(2) polynomial arithmetic: multiply by x, reduce by x^16+poly, add input.
   function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [3:0] f);
      int unsigned v;
      v = int'(s) * 2;
      if (v >= 65536) v = v ^ (65536 + 32'h1021);
      v = v ^ int'(f);
      return v[15:0];
   endfunction

   // x^6+x^5+1: new low bit is the parity of stages 6 and 1.
   function automatic logic [5:0] lfsr_model(input logic [5:0] x);
      int fb;
      int v;
      fb = $countones(x & 6'b100001) % 2;
      v  = (int'(x) * 2) % 64 + fb;
      return v[5:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_x"},    32'(m_x),    32'd0);
      chk({tag, "_busy"}, 32'(m_busy), 32'd0);
      chk({tag, "_done"}, 32'(m_done), 32'd0);
      chk({tag, "_pass"}, 32'(m_pass), 32'd0);
      chk({tag, "_sig"},  32'(m_sig),  32'd0);
      chk({tag, "_cnt"},  32'(m_cnt),  32'd0);
   endtask

   // One run on DUT d. fmode 0 drives fconst, otherwise random responses.
   // abort_at >= 0 asserts rst (with start) on that pattern's capture cycle.
   task automatic do_run(input int d, input int n_pat, input int settle, input logic [15:0] golden,
                         input int fmode, input logic [3:0] fconst, input bit hold, input int abort_at);
      logic [5:0]  mx;
      logic [15:0] ms;
      logic [3:0]  fv;
      sel = d;
      mx  = 6'h01;
      ms  = 16'h0000;
      obs_x.delete();
      start_r[d] = 1'b1;
      step();
      if (!hold) start_r[d] = 1'b0;
      for (int p = 0; p < n_pat; p++) begin
         for (int s = 0; s <= settle; s++) begin
            chk("run_busy", 32'(m_busy), 32'd1);
            chk("run_done", 32'(m_done), 32'd0);
            chk("run_x",    32'(m_x),    32'(mx));
            chk("run_cnt",  32'(m_cnt),  32'(p));
            if (p == 0 && s == 0) chk("run_pass_cleared", 32'(m_pass), 32'd0);
            if (s == 0) obs_x.push_back(m_x);
            fv = (fmode != 0) ? 4'($urandom_range(0, 15)) : fconst;
            f_r[d] = fv;
            if (s == settle) begin
               if (p == abort_at) begin
                  rst        = 1'b1;
                  start_r[d] = 1'b1;
               end
               ms = misr_model(ms, fv);
               mx = lfsr_model(mx);
            end
            step();
            if (p == abort_at && s == settle) begin
               chk_reset("abort");
               rst        = 1'b0;
               start_r[d] = 1'b0;
               step();
               chk("abort_idle_busy", 32'(m_busy), 32'd0);
               return;
            end
         end
      end
      chk("end_done", 32'(m_done), 32'd1);
      chk("end_busy", 32'(m_busy), 32'd0);
      chk("end_pass", 32'(m_pass), 32'(ms == golden));
      chk("end_sig",  32'(m_sig),  32'(ms));
      chk("end_cnt",  32'(m_cnt),  32'(n_pat));
      chk("end_x",    32'(m_x),    32'(mx));
      step();
      chk("post_done", 32'(m_done), 32'd0);
      chk("post_busy", 32'(m_busy), 32'd0);
      start_r[d] = 1'b0;
      step();
      chk("hold_busy", 32'(m_busy), 32'd0);
      chk("hold_done", 32'(m_done), 32'd0);
      chk("hold_sig",  32'(m_sig),  32'(ms));
      chk("hold_cnt",  32'(m_cnt),  32'(n_pat));
      chk("hold_pass", 32'(m_pass), 32'(ms == golden));
      chk("hold_x",    32'(m_x),    32'(mx));
   endtask

   task automatic chk_seq_prefix(input string tag);
      logic [5:0] tbl [7];
      int zeros;
      tbl = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3E};
      for (int i = 0; i < 7; i++) chk(tag, 32'(obs_x[i]), 32'(tbl[i]));
      zeros = 0;
      foreach (obs_x[i]) if (obs_x[i] == 6'h00) zeros++;
      chk({tag, "_nonzero"}, 32'(zeros), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_r[i] = 1'b0;
         f_r[i]     = 4'h0;
      end
      rst = 1'b1;
      start_r[0] = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #0;
         chk_reset("reset");
      end
      start_r[0] = 1'b0;
      rst = 1'b0;
      step();

      // Default config, f_i tied low: zero signature, pass, full LFSR cycle.
      do_run(0, 63, 1, 16'h0000, 0, 4'h0, 1'b0, -1);
      chk_seq_prefix("seq_run1");
      chk("period_x", 32'(m_x), 32'h01);
      repeat (4) step();
      chk("pass_sticky", 32'(m_pass), 32'd1);

      // Random responses, start held through the whole run.
      do_run(0, 63, 1, 16'h0000, 1, 4'h0, 1'b1, -1);
      repeat (2) step();
      chk("single_run_busy", 32'(m_busy), 32'd0);

      // Reset on the 10th capture, then a fresh run from the seed.
      do_run(0, 63, 1, 16'h0000, 1, 4'h0, 1'b0, 9);
      do_run(0, 63, 1, 16'h0000, 1, 4'h0, 1'b0, -1);
      chk_seq_prefix("seq_after_rst");

      // Two patterns, SETTLE=1, all-ones response.
      do_run(1, 2, 1, 16'h0000, 0, 4'hF, 1'b0, -1);
      chk("np2_sig", 32'(m_sig), 32'h0011);
      chk("np2_pass", 32'(m_pass), 32'd0);
      for (int r = 0; r < 3; r++) do_run(1, 2, 1, 16'h0000, 1, 4'h0, 1'b0, -1);

      // SETTLE=0: back-to-back captures.
      do_run(2, 3, 0, 16'h0007, 0, 4'h1, 1'b0, -1);
      for (int r = 0; r < 4; r++) do_run(2, 3, 0, 16'h0007, 1, 4'h0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, limit 1000000 reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
